regfile_onehot_wr: RTL and testbench

- 32-entry x 32-bit general-purpose register file for the single-cycle CPU datapath.
- Sits directly downstream of the 5-to-32 write-address decoder and consumes its one-hot output as the write select.
- Provides two combinational read ports for the ALU operands (rs/rt) and one synchronous write port for the writeback.
- Checks that the incoming write select is one-hot and flags violations.

---
 rtl/regfile_pkg.sv | 12 +
 rtl/regfile_onehot_wr_if.sv | 14 +
 rtl/regfile_onehot_wr_reg_cell.sv | 14 +
 rtl/regfile_onehot_wr.sv | 46 ++++
 tb/tb_regfile_onehot_wr.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared sizes, types and the one-hot check for the register file and its decoder.
package regfile_pkg;
  localparam int DATA_W = 32;
  localparam int NREG = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W = 16;
  typedef logic [DATA_W-1:0] word_t;
  typedef logic [NREG-1:0] onehot_t;
  function automatic logic onehot_ok(onehot_t s);
    return (s != '0) && ((s & (s - onehot_t'(1))) == '0);
  endfunction
endpackage

// File: rtl/regfile_onehot_wr_if.sv
// regfile_onehot_wr_if: write/read bus of the register file; master drives writes and addresses.
interface regfile_onehot_wr_if;
  import regfile_pkg::*;
  onehot_t wsel;
  word_t wdata;
  logic [ADDR_W-1:0] ra;
  logic [ADDR_W-1:0] rb;
  word_t qa;
  word_t qb;
  logic sel_err;
  logic [CNT_W-1:0] wr_cnt;
  modport master(output wsel, wdata, ra, rb, input qa, qb, sel_err, wr_cnt);
  modport slave(input wsel, wdata, ra, rb, output qa, qb, sel_err, wr_cnt);
endinterface

// File: rtl/regfile_onehot_wr_reg_cell.sv
// reg_cell: one data word with async active-high reset and write enable.
module reg_cell
  import regfile_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  we,
  input  word_t d,
  output word_t q
);
  always_ff @(posedge clk or posedge rst)
    if (rst) q <= '0;
    else if (we) q <= d;
endmodule

// File: rtl/regfile_onehot_wr.sv
// regfile_onehot_wr: 32x32 register file with one-hot write select and two combinational reads (REGFILE_BYPASS_EN adds write-to-read forwarding).
module regfile_onehot_wr
  import regfile_pkg::*;
(
  input logic clk,
  input logic rst,
  regfile_onehot_wr_if.slave bus
);
  word_t regs [NREG];
  logic wr_ok;
  logic multi;
  logic sel_err;
  logic [CNT_W-1:0] wr_cnt;
  assign wr_ok = onehot_ok(bus.wsel);
  assign multi = |(bus.wsel & (bus.wsel - onehot_t'(1)));
  assign regs[0] = '0;
  for (genvar i = 1; i < NREG; i++) begin : g_cell
    reg_cell u_cell (
      .clk(clk),
      .rst(rst),
      .we (wr_ok & bus.wsel[i]),
      .d  (bus.wdata),
      .q  (regs[i])
    );
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sel_err <= 1'b0;
      wr_cnt <= '0;
    end else begin
      if (multi) sel_err <= 1'b1;
      if (wr_ok && wr_cnt != '1) wr_cnt <= wr_cnt + CNT_W'(1);
    end
  always_ff @(posedge clk)
    if (!rst) assert (!$isunknown(bus.wsel));
  assign bus.sel_err = sel_err;
  assign bus.wr_cnt = wr_cnt;
`ifdef REGFILE_BYPASS_EN
  // forwarding is gated by rst so reads stay zero while reset is held
  assign bus.qa = (!rst && wr_ok && bus.ra != '0 && bus.wsel[bus.ra]) ? bus.wdata : regs[bus.ra];
  assign bus.qb = (!rst && wr_ok && bus.rb != '0 && bus.wsel[bus.rb]) ? bus.wdata : regs[bus.rb];
`else
  assign bus.qa = regs[bus.ra];
  assign bus.qb = regs[bus.rb];
`endif
endmodule

// File: tb/tb_regfile_onehot_wr.sv
// tb_regfile_onehot_wr: directed table, random traffic against an array model, async reset and counter saturation.
module tb_regfile_onehot_wr;
  import regfile_pkg::*;
`ifdef REGFILE_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  regfile_onehot_wr_if bus ();
  regfile_onehot_wr dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  word_t m [NREG];
  int m_cnt;
  bit m_err;

  typedef struct {
    onehot_t wsel;
    word_t wdata;
    logic [4:0] ra;
    logic [4:0] rb;
    word_t qa;
    word_t qb;
    word_t qa_b;
    word_t qb_b;
    bit err;
    int cnt;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    foreach (m[i]) m[i] = '0;
    m_cnt = 0;
    m_err = 1'b0;
  endtask

  task automatic model_step(input onehot_t w, input word_t d);
    int pc;
    pc = $countones(w);
    if (pc == 1) begin
      for (int k = 1; k < NREG; k++) if (w[k]) m[k] = d;
      if (m_cnt < 65535) m_cnt++;
    end else if (pc >= 2) m_err = 1'b1;
  endtask

  function automatic word_t exp_rd(input int a, input onehot_t w, input word_t d);
    if (a == 0) return '0;
    if (BP && $countones(w) == 1 && w[a]) return d;
    return m[a];
  endfunction

  task automatic drive(input onehot_t w, input word_t d, input int a, input int b);
    bus.wsel = w;
    bus.wdata = d;
    bus.ra = 5'(a);
    bus.rb = 5'(b);
  endtask

  function automatic onehot_t rand_sel();
    int r;
    r = $urandom_range(0, 99);
    if (r < 50) return onehot_t'(1) << $urandom_range(0, 31);
    if (r < 70) return '0;
    if (r < 85) return (onehot_t'(1) << $urandom_range(0, 15)) | (onehot_t'(1) << $urandom_range(16, 31));
    return onehot_t'($urandom);
  endfunction

  vec_t tbl [8];

  initial begin
    tbl[0] = '{32'h20, 32'hDEAD_BEEF, 5, 5, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1};
    tbl[1] = '{32'h0, 32'h0, 5, 5, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, 1};
    tbl[2] = '{32'h1, 32'hFFFF_FFFF, 0, 5, 0, 32'hDEAD_BEEF, 0, 32'hDEAD_BEEF, 0, 2};
    tbl[3] = '{32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 0, 2};
    tbl[4] = '{32'h6, 32'h1234_5678, 1, 2, 0, 0, 0, 0, 1, 2};
    tbl[5] = '{32'h0, 32'h0, 1, 2, 0, 0, 0, 0, 1, 2};
    tbl[6] = '{32'h80, 32'hA5A5_A5A5, 7, 5, 0, 32'hDEAD_BEEF, 32'hA5A5_A5A5, 32'hDEAD_BEEF, 1, 3};
    tbl[7] = '{32'h0, 32'h0, 7, 7, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 32'hA5A5_A5A5, 1, 3};
    model_reset();
    drive('0, '0, 0, 0);
    #1;
    for (int a = 0; a < NREG; a++) begin
      drive('0, '0, a, NREG - 1 - a);
      #1;
      chk("reset_qa", bus.qa, 0);
      chk("reset_qb", bus.qb, 0);
    end
    chk("reset_err", 32'(bus.sel_err), 0);
    chk("reset_cnt", 32'(bus.wr_cnt), 0);
    @(negedge clk);
    rst = 1'b0;
    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].wsel, tbl[i].wdata, tbl[i].ra, tbl[i].rb);
      #1;
      chk($sformatf("tbl%0d_qa", i), bus.qa, BP ? tbl[i].qa_b : tbl[i].qa);
      chk($sformatf("tbl%0d_qb", i), bus.qb, BP ? tbl[i].qb_b : tbl[i].qb);
      model_step(tbl[i].wsel, tbl[i].wdata);
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_err", i), 32'(bus.sel_err), 32'(tbl[i].err));
      chk($sformatf("tbl%0d_cnt", i), 32'(bus.wr_cnt), 32'(tbl[i].cnt));
    end
    for (int i = 0; i < 10; i++) begin
      onehot_t w;
      word_t d;
      w = onehot_t'(1) << $urandom_range(0, 31);
      d = $urandom;
      @(negedge clk);
      drive(w, d, $urandom_range(0, 31), $urandom_range(0, 31));
      model_step(w, d);
      @(posedge clk);
      #1;
      chk("sticky_err", 32'(bus.sel_err), 1);
      chk("sticky_cnt", 32'(bus.wr_cnt), 32'(m_cnt));
    end
    for (int i = 0; i < 400; i++) begin
      onehot_t w;
      word_t d;
      int a;
      int b;
      w = rand_sel();
      d = $urandom;
      a = $urandom_range(0, 31);
      b = $urandom_range(0, 31);
      @(negedge clk);
      drive(w, d, a, b);
      #1;
      chk("rnd_qa", bus.qa, exp_rd(a, w, d));
      chk("rnd_qb", bus.qb, exp_rd(b, w, d));
      model_step(w, d);
      @(posedge clk);
      #1;
      chk("rnd_err", 32'(bus.sel_err), 32'(m_err));
      chk("rnd_cnt", 32'(bus.wr_cnt), 32'(m_cnt));
    end
    @(negedge clk);
    drive(onehot_t'(1) << 31, 32'h0BAD_F00D, 31, 0);
    @(posedge clk);
    #1;
    bus.wsel = '0;
    chk("r31_qa", bus.qa, 32'h0BAD_F00D);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_qa", bus.qa, 0);
    chk("async_cnt", 32'(bus.wr_cnt), 0);
    chk("async_err", 32'(bus.sel_err), 0);
    @(negedge clk);
    drive(onehot_t'(1) << 3, 32'h3333_C0DE, 31, 3);
    @(posedge clk);
    #1;
    chk("rst_dom_qb", bus.qb, 0);
    chk("rst_dom_cnt", 32'(bus.wr_cnt), 0);
    @(negedge clk);
    #2;
    rst = 1'b0;
    model_step(bus.wsel, bus.wdata);
    @(posedge clk);
    #1;
    chk("rel_qb", bus.qb, m[3]);
    chk("rel_cnt", 32'(bus.wr_cnt), 32'(m_cnt));
    @(negedge clk);
    drive(onehot_t'(1) << 2, 32'h5A5A_0002, 2, 3);
    repeat (65536) begin
      @(posedge clk);
      model_step(bus.wsel, bus.wdata);
    end
    #1;
    chk("sat_cnt", 32'(bus.wr_cnt), 32'(m_cnt));
    chk("sat_cnt_max", 32'(bus.wr_cnt), 32'hFFFF);
    chk("sat_qa", bus.qa, 32'h5A5A_0002);
    chk("sat_err", 32'(bus.sel_err), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
